// File: rtl/keypad_pkg.sv
// Shared types and key-map helpers for the 4x4 keypad entry front end.
package keypad_pkg;

  typedef enum logic [3:0] {
    K0 = 4'd0, K1 = 4'd1, K2 = 4'd2, K3 = 4'd3, K4 = 4'd4,
    K5 = 4'd5, K6 = 4'd6, K7 = 4'd7, K8 = 4'd8, K9 = 4'd9,
    KA = 4'd10, KB = 4'd11, KC = 4'd12, KD = 4'd13,
    KSTAR = 4'd14, KHASH = 4'd15
  } key_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2, OP_DIV = 3'd3, OP_EQ = 3'd4
  } op_t;

  typedef enum logic [1:0] {
    S_SCAN = 2'd0, S_DEB = 2'd1, S_HELD = 2'd2
  } scan_st_t;

  function automatic key_t decode(input logic [1:0] row_idx, input logic [1:0] col_idx);
    key_t k;
    case ({row_idx, col_idx})
      4'b00_00: k = K1;    4'b00_01: k = K2;    4'b00_10: k = K3;     4'b00_11: k = KA;
      4'b01_00: k = K4;    4'b01_01: k = K5;    4'b01_10: k = K6;     4'b01_11: k = KB;
      4'b10_00: k = K7;    4'b10_01: k = K8;    4'b10_10: k = K9;     4'b10_11: k = KC;
      4'b11_00: k = KSTAR; 4'b11_01: k = K0;    4'b11_10: k = KHASH;  default:  k = KD;
    endcase
    return k;
  endfunction

  // With several rows low, the lowest-index row is reported.
  function automatic logic [1:0] lowest_low(input logic [3:0] row);
    logic [1:0] r;
    r = 2'd3;
    for (int i = 3; i >= 0; i--) begin
      if (!row[i]) r = 2'(i);
    end
    return r;
  endfunction

  function automatic op_t key_to_op(input key_t k);
    op_t o;
    case (k)
      KA:      o = OP_ADD;
      KB:      o = OP_SUB;
      KC:      o = OP_MUL;
      KD:      o = OP_DIV;
      default: o = OP_EQ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/keypad_entry_if.sv
// Display and commit bus from the keypad entry block to the ALU/control path.
interface keypad_entry_if #(
  parameter int DIGITS = 4
);
  import keypad_pkg::*;

  logic [DIGITS*4-1:0]          digits_out;
  logic [$clog2(DIGITS+1)-1:0]  count;
  logic [DIGITS*4-1:0]          operand;
  op_t                          op;
  logic                         operand_valid;
  logic                         overflow;

  modport master (
    output digits_out, count, operand, op, operand_valid, overflow
  );

  modport slave (
    input digits_out, count, operand, op, operand_valid, overflow
  );

endinterface

// File: rtl/keypad_scanner.sv
// Column scanner with row debounce; emits one key_valid pulse per accepted press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output key_t       key_code,
  output logic       key_valid
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DEB_W = $clog2(DEBOUNCE + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE - 1);

  scan_st_t         state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       colidx_q, colidx_d;
  logic [DEB_W-1:0] cnt_q, cnt_d;
  logic [3:0]       pat_q, pat_d;
  key_t             key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    colidx_d    = colidx_q;
    cnt_d       = cnt_q;
    pat_d       = pat_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    case (state_q)
      S_SCAN: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (row != 4'hF) begin
            state_d = S_DEB;
            pat_d   = row;
            cnt_d   = '0;
          end else begin
            colidx_d = colidx_q + 2'd1;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_DEB: begin
        if (row == pat_q) begin
          if (cnt_q == DEB_LAST) begin
            state_d     = S_HELD;
            cnt_d       = '0;
            key_valid_d = 1'b1;
            key_code_d  = decode(lowest_low(pat_q), colidx_q);
          end else begin
            cnt_d = cnt_q + DEB_W'(1);
          end
        end else begin
          state_d  = S_SCAN;
          colidx_d = colidx_q + 2'd1;
          div_d    = '0;
          cnt_d    = '0;
        end
      end
      S_HELD: begin
        // Only an unbroken run of all-high samples counts as a release.
        if (row == 4'hF) begin
          if (cnt_q == DEB_LAST) begin
            state_d  = S_SCAN;
            colidx_d = colidx_q + 2'd1;
            div_d    = '0;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + DEB_W'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: begin
        state_d  = S_SCAN;
        div_d    = '0;
        cnt_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_SCAN;
      div_q       <= '0;
      colidx_q    <= 2'd0;
      cnt_q       <= '0;
      key_code_q  <= K0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      colidx_q    <= colidx_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    pat_q <= pat_d;
  end

  assign col       = ~(4'b0001 << colidx_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;

endmodule

// File: rtl/keypad_entry.sv
// Keypad front end: scanner plus BCD entry buffer with backspace, overflow and commit.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           row,
  output logic [3:0]           col,
  input  logic                 clear,
  output key_t                 key_code,
  output logic                 key_valid,
  keypad_entry_if.master       bus
);

  localparam int BUF_W = DIGITS * 4;
  localparam int CNT_W = $clog2(DIGITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIGITS);

  logic [BUF_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BUF_W-1:0] operand_q, operand_d;
  op_t              op_q, op_d;
  logic             opv_q, opv_d;
  logic             ovf_q, ovf_d;

  keypad_scanner #(
    .SCAN_DIV (SCAN_DIV),
    .DEBOUNCE (DEBOUNCE)
  ) u_scan (
    .clk       (clk),
    .reset     (reset),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid)
  );

  always_comb begin
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    operand_d = operand_q;
    op_d      = op_q;
    opv_d     = 1'b0;
    ovf_d     = 1'b0;
    // clear drops any key action landing in the same cycle.
    if (clear) begin
      buf_d = '0;
      cnt_d = '0;
    end else if (key_valid) begin
      if (key_code <= K9) begin
        if (cnt_q < CNT_FULL) begin
          buf_d = (buf_q << 4) | BUF_W'(key_code);
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end else if (key_code == KSTAR) begin
        if (cnt_q != '0) begin
          buf_d = buf_q >> 4;
          cnt_d = cnt_q - CNT_W'(1);
        end
      end else begin
        operand_d = buf_q;
        op_d      = key_to_op(key_code);
        opv_d     = 1'b1;
        buf_d     = '0;
        cnt_d     = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q     <= '0;
      cnt_q     <= '0;
      operand_q <= '0;
      op_q      <= OP_EQ;
      opv_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      buf_q     <= buf_d;
      cnt_q     <= cnt_d;
      operand_q <= operand_d;
      op_q      <= op_d;
      opv_q     <= opv_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.digits_out    = buf_q;
  assign bus.count         = cnt_q;
  assign bus.operand       = operand_q;
  assign bus.op            = op_q;
  assign bus.operand_valid = opv_q;
  assign bus.overflow      = ovf_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry with a behavioural keypad matrix model.
module tb_keypad_entry;
  import keypad_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic [3:0] col;
  wire  [3:0] row;
  key_t       key_code;
  logic       key_valid;

  logic       key_on;
  logic [1:0] key_r, key_c;
  logic       row_ovr_en;
  logic [3:0] row_ovr;

  int checks = 0;
  int errors = 0;
  int kv_cnt = 0;
  int ov_cnt = 0;
  int opv_cnt = 0;

  keypad_entry_if #(.DIGITS(4)) bus ();

  keypad_entry #(
    .DIGITS   (4),
    .SCAN_DIV (4),
    .DEBOUNCE (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .row       (row),
    .col       (col),
    .clear     (clear),
    .key_code  (key_code),
    .key_valid (key_valid),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Pressed switch connects its row to its column while that column is driven low.
  assign row = row_ovr_en ? row_ovr :
               (key_on && (col[key_c] == 1'b0)) ? ~(4'b0001 << key_r) : 4'hF;

  always @(posedge clk) begin
    if (key_valid)         kv_cnt  <= kv_cnt + 1;
    if (bus.overflow)      ov_cnt  <= ov_cnt + 1;
    if (bus.operand_valid) opv_cnt <= opv_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic locate(input key_t k);
    case (k)
      K1: begin key_r = 0; key_c = 0; end  K2: begin key_r = 0; key_c = 1; end
      K3: begin key_r = 0; key_c = 2; end  KA: begin key_r = 0; key_c = 3; end
      K4: begin key_r = 1; key_c = 0; end  K5: begin key_r = 1; key_c = 1; end
      K6: begin key_r = 1; key_c = 2; end  KB: begin key_r = 1; key_c = 3; end
      K7: begin key_r = 2; key_c = 0; end  K8: begin key_r = 2; key_c = 1; end
      K9: begin key_r = 2; key_c = 2; end  KC: begin key_r = 2; key_c = 3; end
      KSTAR: begin key_r = 3; key_c = 0; end K0: begin key_r = 3; key_c = 1; end
      KHASH: begin key_r = 3; key_c = 2; end default: begin key_r = 3; key_c = 3; end
    endcase
  endtask

  task automatic wait_kv(input int c0, input string tag);
    int n = 0;
    while (kv_cnt == c0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (kv_cnt != c0) else begin
      errors++;
      $error("FAIL %s observed=no_key_valid expected=key_valid", tag);
    end
  endtask

  task automatic release_key();
    key_on = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic press(input key_t k, input int hold);
    int c0;
    c0 = kv_cnt;
    locate(k);
    key_on = 1'b1;
    wait_kv(c0, "press_timeout");
    repeat (hold) @(negedge clk);
    release_key();
  endtask

  task automatic do_clear();
    @(negedge clk) clear = 1'b1;
    @(negedge clk) clear = 1'b0;
  endtask

  initial begin : stim
    int kv0, ov0, opv0;
    logic [3:0] c_prev;
    int n;
    reset = 1'b1; clear = 1'b0; key_on = 1'b0; key_r = 0; key_c = 0;
    row_ovr_en = 1'b0; row_ovr = 4'hF;

    // 1: reset state
    repeat (2) @(negedge clk);
    chk("rst_col", col, 4'b1110);
    chk("rst_digits", bus.digits_out, 16'h0000);
    chk("rst_count", bus.count, 0);
    chk("rst_operand", bus.operand, 16'h0000);
    chk("rst_op", bus.op, OP_EQ);
    chk("rst_key_code", key_code, K0);
    chk("rst_pulses", {key_valid, bus.overflow, bus.operand_valid}, 3'b000);
    reset = 1'b0;

    // 2: digit entry
    kv0 = kv_cnt;
    press(K1, 4); press(K2, 4); press(K3, 4);
    chk("entry_kv_pulses", kv_cnt - kv0, 3);
    chk("entry_digits", bus.digits_out, 16'h0123);
    chk("entry_count", bus.count, 3);
    chk("entry_key_code", key_code, K3);

    // 3: overflow on the fifth digit
    do_clear();
    ov0 = ov_cnt;
    press(K9, 3); press(K8, 3); press(K7, 3); press(K6, 3);
    chk("full_no_ovf", ov_cnt - ov0, 0);
    press(K5, 3);
    chk("ovf_pulses", ov_cnt - ov0, 1);
    chk("ovf_digits", bus.digits_out, 16'h9876);
    chk("ovf_count", bus.count, 4);

    // 4: backspace then commit with ADD
    do_clear();
    press(K4, 3); press(K2, 3);
    chk("bs_pre_digits", bus.digits_out, 16'h0042);
    press(KSTAR, 3);
    chk("bs_digits", bus.digits_out, 16'h0004);
    chk("bs_count", bus.count, 1);
    opv0 = opv_cnt;
    press(KA, 3);
    chk("commit_operand", bus.operand, 16'h0004);
    chk("commit_op", bus.op, OP_ADD);
    chk("commit_pulses", opv_cnt - opv0, 1);
    chk("commit_digits", bus.digits_out, 16'h0000);
    chk("commit_count", bus.count, 0);

    // 5: two-cycle glitch aligned to the end of a scan slot, then a long hold
    kv0 = kv_cnt;
    c_prev = col;
    n = 0;
    @(negedge clk);
    while (col == c_prev && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    row_ovr = 4'b1110; row_ovr_en = 1'b1;
    repeat (2) @(negedge clk);
    row_ovr_en = 1'b0; row_ovr = 4'hF;
    repeat (12) @(negedge clk);
    chk("glitch_no_key", kv_cnt - kv0, 0);
    press(K7, 20);
    chk("hold_one_key", kv_cnt - kv0, 1);
    chk("hold_key_code", key_code, K7);
    chk("hold_digits", bus.digits_out, 16'h0007);

    // 6a: clear in the same cycle as the entry action
    ov0 = ov_cnt; opv0 = opv_cnt; kv0 = kv_cnt;
    locate(K5);
    key_on = 1'b1;
    n = 0;
    while (!key_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("race_kv_seen", key_valid, 1'b1);
    clear = 1'b1;
    @(negedge clk) clear = 1'b0;
    release_key();
    chk("race_digits", bus.digits_out, 16'h0000);
    chk("race_count", bus.count, 0);
    chk("race_pulses", (ov_cnt - ov0) + (opv_cnt - opv0), 0);
    chk("race_operand_hold", bus.operand, 16'h0004);

    // 6b: reset while a key is held
    kv0 = kv_cnt;
    locate(K3);
    key_on = 1'b1;
    wait_kv(kv0, "held_first_timeout");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    chk("rstheld_state", dut.u_scan.state_q, S_SCAN);
    chk("rstheld_col", col, 4'b1110);
    chk("rstheld_digits", bus.digits_out, 16'h0000);
    kv0 = kv_cnt;
    wait_kv(kv0, "held_repress_timeout");
    repeat (6) @(negedge clk);
    release_key();
    chk("rstheld_one_press", kv_cnt - kv0, 1);
    chk("rstheld_key_code", key_code, K3);
    chk("rstheld_new_digits", bus.digits_out, 16'h0003);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
